// File: rtl/sys_array_pkg.sv
// Shared constants and types for the systolic MAC array and its readout queue.
package sys_array_pkg;

  localparam int unsigned ACC_W_DEFAULT = 21;
  localparam int unsigned SLICES_LEGAL [4] = '{1, 2, 4, 8};

  localparam logic [7:0] INT8_MAX = 8'h7F;
  localparam logic [7:0] INT8_MIN = 8'h80;

  typedef enum logic {
    Q_IDLE,
    Q_STREAM
  } q_state_t;

  function automatic bit slices_legal(input int unsigned s);
    slices_legal = 1'b0;
    foreach (SLICES_LEGAL[i]) begin
      if (SLICES_LEGAL[i] == s) slices_legal = 1'b1;
    end
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// Beat input / result stream bundle of the systolic MAC array.
interface systolic_mac_array_if;

  logic [7:0] in_left;
  logic [7:0] in_top;
  logic       in_valid;
  logic       signed_top;
  logic       relu_en;
  logic       start_readout;
  logic [7:0] out;
  logic       out_valid;
  logic       out_overflow;
  logic       busy;

  modport master (
    output in_left, in_top, in_valid, signed_top, relu_en, start_readout,
    input  out, out_valid, out_overflow, busy
  );

  modport slave (
    input  in_left, in_top, in_valid, signed_top, relu_en, start_readout,
    output out, out_valid, out_overflow, busy
  );

endinterface

// File: rtl/mac_out_queue.sv
// Snapshot store for the accumulators; streams them row-major through
// arithmetic shift, optional ReLU and INT8 saturation.
module mac_out_queue
  import sys_array_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned ACC_W     = ACC_W_DEFAULT,
  parameter int unsigned OUT_SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snap,
  input  logic             relu_en,
  input  logic [ACC_W-1:0] acc_in [N],
  input  logic [N-1:0]     ovf_in,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic             out_overflow
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  q_state_t         state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [ACC_W-1:0] q [N];
  logic [N-1:0]     q_ovf;
  logic             relu_q;
  logic [ACC_W-1:0] shifted;
  logic             fits;
  logic             stream;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= Q_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      Q_IDLE: begin
        if (snap) begin
          state_nxt = Q_STREAM;
          idx_nxt   = '0;
        end
      end
      Q_STREAM: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) state_nxt = Q_IDLE;
      end
      default: state_nxt = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '{default: '0};
      q_ovf  <= '0;
      relu_q <= 1'b0;
    end else if (snap) begin
      q      <= acc_in;
      q_ovf  <= ovf_in;
      relu_q <= relu_en;
    end
  end

  // Value fits INT8 when every bit above bit 7 equals the sign bit.
  always_comb begin
    stream  = (state == Q_STREAM);
    shifted = $signed(q[idx]) >>> OUT_SHIFT;
    if (relu_q && shifted[ACC_W-1]) shifted = '0;
    fits = (&shifted[ACC_W-1:7]) | ~(|shifted[ACC_W-1:7]);
    out          = '0;
    out_overflow = 1'b0;
    out_valid    = stream;
    if (stream) begin
      out          = fits ? shifted[7:0] : (shifted[ACC_W-1] ? INT8_MIN : INT8_MAX);
      out_overflow = q_ovf[idx] | ~fits;
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// Weight-stationary MAC array: beats fill a double-buffered tile, the engine
// sweeps one column per cycle with saturating accumulation, readout streams INT8.
module systolic_mac_array
  import sys_array_pkg::*;
#(
  parameter int unsigned SLICES    = 4,
  parameter int unsigned ACC_W     = ACC_W_DEFAULT,
  parameter int unsigned OUT_SHIFT = 8
) (
  input logic                 clk,
  input logic                 reset,
  systolic_mac_array_if.slave bus
);

  localparam int unsigned H     = 2 * SLICES;
  localparam int unsigned W     = SLICES;
  localparam int unsigned N     = H * W;
  localparam int unsigned CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] eng_col;
  logic             eng_act;
  logic             pend;
  logic             streaming;
  logic             commit;
  logic             snap;

  logic [3:0]       w_nxt [H];
  logic [3:0]       w_load [H];
  logic [3:0]       w_cur [H];
  logic [8:0]       a_nxt [W];
  logic [8:0]       a_load [W];
  logic [8:0]       a_cur [W];
  logic [ACC_W-1:0] acc [N];
  logic [N-1:0]     acc_ovf;
  logic [ACC_W:0]   mac_res [N];

  // Returns {saturated, value}; product is at most 13 bits signed.
  function automatic logic [ACC_W:0] mac_sat(input logic [ACC_W-1:0] acc_v,
                                             input logic [3:0] w_v,
                                             input logic [8:0] a_v);
    logic [12:0]    prod;
    logic [ACC_W:0] sum;
    prod = {{9{w_v[3]}}, w_v} * {{4{a_v[8]}}, a_v};
    sum  = {acc_v[ACC_W-1], acc_v} + {{(ACC_W-12){prod[12]}}, prod};
    if (sum[ACC_W] != sum[ACC_W-1])
      mac_sat = {1'b1, sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
    else
      mac_sat = {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign commit    = bus.in_valid && (beat_cnt == LAST);
  assign snap      = pend && !eng_act && !commit;
  assign streaming = bus.out_valid;
  assign bus.busy  = eng_act | pend | streaming;

  // The committing beat is merged here so the tile swap sees all of it.
  always_comb begin
    w_load = w_nxt;
    a_load = a_nxt;
    for (int unsigned b = 0; b < SLICES; b++) begin
      if (bus.in_valid && (beat_cnt == CNT_W'(b))) begin
        w_load[2*b]   = bus.in_left[3:0];
        w_load[2*b+1] = bus.in_left[7:4];
        a_load[b]     = {bus.signed_top & bus.in_top[7], bus.in_top};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      eng_col  <= '0;
      eng_act  <= 1'b0;
      pend     <= 1'b0;
      w_nxt    <= '{default: '0};
      w_cur    <= '{default: '0};
      a_nxt    <= '{default: '0};
      a_cur    <= '{default: '0};
    end else begin
      w_nxt <= w_load;
      a_nxt <= a_load;
      if (commit) begin
        w_cur <= w_load;
        a_cur <= a_load;
      end

      if (snap)
        beat_cnt <= '0;
      else if (bus.in_valid)
        beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;

      if (commit) begin
        eng_act <= 1'b1;
        eng_col <= '0;
      end else if (eng_act) begin
        eng_act <= (eng_col != LAST);
        eng_col <= eng_col + 1'b1;
      end

      if (snap)
        pend <= 1'b0;
      else if (bus.start_readout && !streaming)
        pend <= 1'b1;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < H; r++) begin
      for (int unsigned c = 0; c < W; c++) begin
        mac_res[r*W+c] = mac_sat(acc[r*W+c], w_cur[r], a_cur[c]);
      end
    end
  end

  // Snapshot and engine never coincide: snapshot requires the engine idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '{default: '0};
      acc_ovf <= '0;
    end else if (snap) begin
      acc     <= '{default: '0};
      acc_ovf <= '0;
    end else if (eng_act) begin
      for (int unsigned r = 0; r < H; r++) begin
        for (int unsigned c = 0; c < W; c++) begin
          if (eng_col == CNT_W'(c)) begin
            acc[r*W+c]     <= mac_res[r*W+c][ACC_W-1:0];
            acc_ovf[r*W+c] <= acc_ovf[r*W+c] | mac_res[r*W+c][ACC_W];
          end
        end
      end
    end
  end

  mac_out_queue #(
    .N        (N),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_out_queue (
    .clk         (clk),
    .reset       (reset),
    .snap        (snap),
    .relu_en     (bus.relu_en),
    .acc_in      (acc),
    .ovf_in      (acc_ovf),
    .out         (bus.out),
    .out_valid   (bus.out_valid),
    .out_overflow(bus.out_overflow)
  );

endmodule

// File: doc/systolic_mac_array.md
SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 Parameter SLICES, default 4, legal values 1/2/4/8; array is H=2*SLICES rows by W=SLICES columns.
REQ-002 Parameter ACC_W, default 21, signed accumulator width, legal range 13..32.
REQ-003 Parameter OUT_SHIFT, default 8, arithmetic right shift applied at readout, legal range 0..ACC_W-8.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_left  in  8  two signed 4-bit weights per beat.
REQ-007 in_top  in  8  one 8-bit activation per beat.
REQ-008 in_valid  in  1  qualifies in_left/in_top as one beat.
REQ-009 signed_top  in  1  1 = in_top signed, 0 = unsigned; sampled with each beat.
REQ-010 relu_en  in  1  clamp negative results to 0; sampled at snapshot.
REQ-011 start_readout  in  1  single-cycle request to snapshot and stream accumulators.
REQ-012 out  out  8  post-processed result element.
REQ-013 out_valid  out  1  qualifies out.
REQ-014 out_overflow  out  1  element saturated (accumulator or output clamp); valid with out_valid.
REQ-015 busy  out  1  compute engine active, or readout pending/active.

Function
REQ-016 Beat b (0..SLICES-1 within a tile) loads in_left[3:0] to row 2b, in_left[7:4] to row 2b+1, in_top to column b, extended per signed_top to 9 bits.
REQ-017 A beat counter advances only on in_valid; on beat SLICES-1 the tile commits (next to current buffer) at that edge and the counter wraps to 0.
REQ-018 After commit, the engine updates column k (k = 0..SLICES-1) on the k-th following edge: acc[r][k] += w[r]*a[k] for all H rows; the tile is complete SLICES edges after commit.
REQ-019 Loading of the next tile overlaps computation; a new commit never occurs before the engine finishes, given REQ-017.
REQ-020 Accumulation saturates at signed ACC_W limits; a per-accumulator sticky overflow bit is set on saturation.
REQ-021 start_readout sets a pending flag; the snapshot occurs at the first edge with pending set, engine idle, and no commit on that edge.
REQ-022 At snapshot: all accumulators copy to the out queue with their overflow bits, then accumulators and overflow bits clear to 0, the beat counter clears (partial tile discarded), and relu_en is latched.
REQ-023 out_valid is high for exactly H*W consecutive cycles starting the cycle after the snapshot, emitting elements in row-major order, index r*W+c.
REQ-024 Element value: acc >>> OUT_SHIFT, then 0 if negative and relu_en, then clamp to [-128,127]; out_overflow = stored overflow bit OR clamp applied.
REQ-025 start_readout while pending or while streaming is ignored.
REQ-026 in_valid beats are accepted during streaming and accumulate into the cleared accumulators.

Reset
REQ-027 Reset clears accumulators, overflow bits, buffers, counters, and the pending flag; out=0, out_valid=0, out_overflow=0, busy=0.
REQ-028 Reset mid-compute or mid-stream aborts immediately; no further out_valid until a new snapshot.

Structure
REQ-029 Shared package sys_array_pkg holds ACC_W default, legal SLICES list, and the INT8 clamp limits.
REQ-030 The out queue with shift/ReLU/clamp post-processing is a sub-module named mac_out_queue.

Verification
REQ-031 SLICES=2, OUT_SHIFT=0, in_left=0x11, in_top=0x10 signed for 2 beats, then readout -> 8 elements of 16, no overflow.
REQ-032 OUT_SHIFT=0, weights 0x88 (-8), in_top=0x80 signed (-128), one tile -> all elements 127, out_overflow=1.
REQ-033 OUT_SHIFT=1, weights 0x11, in_top=0xFF with signed_top=0 -> 127; with signed_top=1 -> -1 (0xFF).
REQ-034 Weights 0xFF (-1), in_top=5, OUT_SHIFT=0: relu_en=0 -> 0xFB; relu_en=1 -> 0x00.
REQ-035 start_readout asserted on the commit edge -> snapshot deferred until the engine is idle and includes the full tile; a second start_readout during streaming is ignored.
REQ-036 Reset asserted during streaming -> out_valid drops immediately; a subsequent readout returns only post-reset sums.
